mux8_rr_sequencer: RTL and testbench

//  Round-robin sequencer that shares one 8-input TTL multiplexer (S[2:0] select,

---
 rtl/mux8_rr_sequencer_pkg.sv | 29 ++
 rtl/mux8_rr_sequencer_rr_find8.sv | 32 +++
 rtl/mux8_rr_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_mux8_rr_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux8_rr_sequencer_pkg.sv
// Shared definitions for the 8-way round-robin mux sequencer: sizes,
// FSM state encoding and small select helpers.
package mux8_rr_sequencer_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  // Sequencer phases; encodings are fixed so they read the same on a waveform
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GRANT  = 2'd2,
    ST_GAP    = 2'd3
  } seqState_t;

  // One-hot grant vector for a given select value
  function automatic logic [NUM_REQ-1:0] selToOnehot(input logic [SEL_W-1:0] sel);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

  // Next round-robin start position; the 3-bit add wraps 7 -> 0 by itself
  function automatic logic [SEL_W-1:0] nextSel(input logic [SEL_W-1:0] sel);
    return sel + SEL_W'(1);
  endfunction

endpackage

// File: rtl/mux8_rr_sequencer_rr_find8.sv
// Combinational round-robin finder: returns the first set request bit
// scanning ptr, ptr+1, ... with wrap-around modulo 8.
module rr_find8
  import mux8_rr_sequencer_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] w_rotated;
  logic [SEL_W-1:0]   w_offset;

  // Rotate the request vector so ptr lands on bit 0, then take the lowest set bit
  always_comb begin
    w_rotated = '0;
    w_offset  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rotated[i] = req[ptr + SEL_W'(i)];
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rotated[i]) begin
        w_offset = SEL_W'(i);
      end
    end
  end

  assign any = |req;
  assign idx = ptr + w_offset;

endmodule

// File: rtl/mux8_rr_sequencer.sv
// Round-robin sequencer sharing one 8:1 TTL mux between 8 requesters.
// Picks a winner, drives the select, lets the mux settle, grants the winner
// and captures the mux Y output. A disabled GAP cycle always separates grants.
module mux8_rr_sequencer
  import mux8_rr_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_HOLD      = 16
) (
  input  logic               clk,
  input  logic               reset_bar,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mux_y,
  output logic [SEL_W-1:0]   mux_s,
  output logic               mux_oe_bar,
  output logic [NUM_REQ-1:0] grant,
  output logic               y_q,
  output logic               busy,
  output logic               timeout
);

  // A zero settle time still needs a one-bit counter to keep the netlist legal
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int SET_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  seqState_t          r_state;
  logic [SEL_W-1:0]   r_muxS;
  logic               r_oeBar;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_yQ;
  logic               r_busy;
  logic               r_timeout;
  logic [SEL_W-1:0]   r_ptr;
  logic [SET_W-1:0]   r_settleCnt;
  logic [HOLD_W-1:0]  r_holdCnt;

  seqState_t          w_stateNext;
  logic [SEL_W-1:0]   w_muxSNext;
  logic               w_oeBarNext;
  logic [NUM_REQ-1:0] w_grantNext;
  logic               w_yQNext;
  logic               w_busyNext;
  logic               w_timeoutNext;
  logic [SEL_W-1:0]   w_ptrNext;
  logic [SET_W-1:0]   w_settleCntNext;
  logic [HOLD_W-1:0]  w_holdCntNext;

  logic               w_any;
  logic [SEL_W-1:0]   w_idx;
  logic               w_curReq;
  logic               w_settleDone;
  logic               w_holdDone;

  rr_find8 u_find (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  assign w_curReq     = req[r_muxS];
  assign w_settleDone = (r_settleCnt == SET_W'(1));
  assign w_holdDone   = (r_holdCnt == HOLD_W'(MAX_HOLD));

  // State and every output register; reset drops the mux enable immediately
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state     <= ST_IDLE;
      r_muxS      <= '0;
      r_oeBar     <= 1'b1;
      r_grant     <= '0;
      r_yQ        <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_ptr       <= '0;
      r_settleCnt <= '0;
      r_holdCnt   <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_muxS      <= w_muxSNext;
      r_oeBar     <= w_oeBarNext;
      r_grant     <= w_grantNext;
      r_yQ        <= w_yQNext;
      r_busy      <= w_busyNext;
      r_timeout   <= w_timeoutNext;
      r_ptr       <= w_ptrNext;
      r_settleCnt <= w_settleCntNext;
      r_holdCnt   <= w_holdCntNext;
    end
  end

  // Phase sequencing; a dropped request always wins over counter expiry
  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_stateNext = (SETTLE_CYCLES == 0) ? ST_GRANT : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!w_curReq) begin
          w_stateNext = ST_GAP;
        end else if (w_settleDone) begin
          w_stateNext = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!w_curReq || w_holdDone) begin
          w_stateNext = ST_GAP;
        end
      end
      ST_GAP: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, pointer and counters for each phase
  always_comb begin
    w_muxSNext      = r_muxS;
    w_oeBarNext     = r_oeBar;
    w_grantNext     = r_grant;
    w_yQNext        = r_yQ;
    w_timeoutNext   = 1'b0;
    w_ptrNext       = r_ptr;
    w_settleCntNext = r_settleCnt;
    w_holdCntNext   = r_holdCnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_muxSNext  = w_idx;
          w_oeBarNext = 1'b0;
          if (SETTLE_CYCLES == 0) begin
            w_grantNext   = selToOnehot(w_idx);
            w_yQNext      = mux_y;
            w_holdCntNext = HOLD_W'(1);
          end else begin
            w_settleCntNext = SET_W'(SETTLE_CYCLES);
          end
        end
      end
      ST_SETTLE: begin
        if (!w_curReq) begin
          w_oeBarNext = 1'b1;
          w_ptrNext   = nextSel(r_muxS);
        end else if (w_settleDone) begin
          w_grantNext   = selToOnehot(r_muxS);
          w_yQNext      = mux_y;
          w_holdCntNext = HOLD_W'(1);
        end else begin
          w_settleCntNext = r_settleCnt - SET_W'(1);
        end
      end
      ST_GRANT: begin
        if (!w_curReq || w_holdDone) begin
          w_grantNext   = '0;
          w_oeBarNext   = 1'b1;
          w_ptrNext     = nextSel(r_muxS);
          w_timeoutNext = w_curReq;
        end else begin
          w_holdCntNext = r_holdCnt + HOLD_W'(1);
        end
      end
      ST_GAP: begin
        w_oeBarNext = 1'b1;
        w_grantNext = '0;
      end
      default: begin
        w_oeBarNext = 1'b1;
        w_grantNext = '0;
      end
    endcase
  end

  // Busy follows the phase being entered so it stays a clean registered output
  always_comb begin
    w_busyNext = (w_stateNext != ST_IDLE);
  end

  assign mux_s      = r_muxS;
  assign mux_oe_bar = r_oeBar;
  assign grant      = r_grant;
  assign y_q        = r_yQ;
  assign busy       = r_busy;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_mux8_rr_sequencer.sv
// Bench for mux8_rr_sequencer: two instances (settle 2 / hold 16 and
// settle 0 / hold 3) share one stimulus stream and are each compared every
// cycle against a behavioural model, plus directed literal expectations.
module tb_mux8_rr_sequencer;

  logic       clk = 1'b0;
  logic       reset_bar;
  logic [7:0] req;
  logic       mux_y;

  logic [2:0] sA, sB;
  logic       oeA, oeB;
  logic [7:0] gA, gB;
  logic       yA, yB, bA, bB, tA, tB;

  int checkCount = 0;
  int passCount  = 0;

  // Model state, index 0 = instance A, 1 = instance B
  int mSet[2] = '{2, 0};
  int mMax[2] = '{16, 3};
  bit mInSettle[2], mInGrant[2], mInGap[2];
  int mCur[2], mPtr[2], mSettleLeft[2], mHoldUsed[2];
  int eS[2], eOe[2], eGrant[2], eYq[2], eBusy[2], eTo[2];

  int grantOrderA[$];
  int timeoutsA = 0;
  logic [7:0] prevGA = '0;

  always #5 clk = ~clk;

  mux8_rr_sequencer #(.SETTLE_CYCLES(2), .MAX_HOLD(16)) dutA (
    .clk(clk), .reset_bar(reset_bar), .req(req), .mux_y(mux_y),
    .mux_s(sA), .mux_oe_bar(oeA), .grant(gA), .y_q(yA), .busy(bA), .timeout(tA)
  );

  mux8_rr_sequencer #(.SETTLE_CYCLES(0), .MAX_HOLD(3)) dutB (
    .clk(clk), .reset_bar(reset_bar), .req(req), .mux_y(mux_y),
    .mux_s(sB), .mux_oe_bar(oeB), .grant(gB), .y_q(yB), .busy(bB), .timeout(tB)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic modelReset(input int n);
    mInSettle[n] = 0; mInGrant[n] = 0; mInGap[n] = 0;
    mCur[n] = 0; mPtr[n] = 0; mSettleLeft[n] = 0; mHoldUsed[n] = 0;
    eS[n] = 0; eOe[n] = 1; eGrant[n] = 0; eYq[n] = 0; eBusy[n] = 0; eTo[n] = 0;
  endtask

  task automatic modelEnterGrant(input int n, input logic y);
    mInGrant[n]  = 1;
    mHoldUsed[n] = 1;
    eGrant[n]    = 1 << mCur[n];
    eYq[n]       = y;
  endtask

  // One clock edge of the sequencer as described by its rules
  task automatic modelStep(input int n, input logic [7:0] r, input logic y);
    bit found;
    eTo[n] = 0;
    if (mInGap[n]) begin
      mInGap[n] = 0;
    end else if (mInSettle[n]) begin
      if (!r[mCur[n]]) begin
        mInSettle[n] = 0; mInGap[n] = 1;
        mPtr[n] = (mCur[n] + 1) % 8;
        eOe[n] = 1;
      end else begin
        mSettleLeft[n]--;
        if (mSettleLeft[n] == 0) begin
          mInSettle[n] = 0;
          modelEnterGrant(n, y);
        end
      end
    end else if (mInGrant[n]) begin
      if (!r[mCur[n]] || mHoldUsed[n] == mMax[n]) begin
        eTo[n] = r[mCur[n]] ? 1 : 0;
        mInGrant[n] = 0; mInGap[n] = 1;
        mPtr[n] = (mCur[n] + 1) % 8;
        eGrant[n] = 0; eOe[n] = 1;
      end else begin
        mHoldUsed[n]++;
      end
    end else if (r != 8'h00) begin
      found = 0;
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(mPtr[n] + k) % 8]) begin
          found = 1;
          mCur[n] = (mPtr[n] + k) % 8;
        end
      end
      eS[n] = mCur[n]; eOe[n] = 0;
      if (mSet[n] == 0) modelEnterGrant(n, y);
      else begin
        mInSettle[n] = 1;
        mSettleLeft[n] = mSet[n];
      end
    end
    eBusy[n] = (mInSettle[n] || mInGrant[n] || mInGap[n]) ? 1 : 0;
  endtask

  always @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      modelReset(0);
      modelReset(1);
    end else begin
      modelStep(0, req, mux_y);
      modelStep(1, req, mux_y);
    end
  end

  task automatic compareInst(input string pfx, input int n, input logic [2:0] s, input logic oe,
                             input logic [7:0] g, input logic y, input logic b, input logic t);
    checkOutput({pfx, ".mux_s"}, s, eS[n]);
    checkOutput({pfx, ".mux_oe_bar"}, oe, eOe[n]);
    checkOutput({pfx, ".grant"}, g, eGrant[n]);
    checkOutput({pfx, ".y_q"}, y, eYq[n]);
    checkOutput({pfx, ".busy"}, b, eBusy[n]);
    checkOutput({pfx, ".timeout"}, t, eTo[n]);
  endtask

  // Per-cycle comparison against the model, plus grant-order bookkeeping for A
  always @(negedge clk) begin
    if (reset_bar) begin
      compareInst("A", 0, sA, oeA, gA, yA, bA, tA);
      compareInst("B", 1, sB, oeB, gB, yB, bB, tB);
      if (gA != 8'h00 && prevGA == 8'h00) grantOrderA.push_back($clog2(gA));
      if (tA) timeoutsA++;
      prevGA = gA;
    end else begin
      prevGA = '0;
    end
  end

  task automatic applyStimulus(input logic [7:0] r, input logic y);
    req   = r;
    mux_y = y;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_bar = 1'b0;
    applyStimulus(8'h00, 1'b0);
    repeat (2) @(negedge clk);
    grantOrderA.delete();
    timeoutsA = 0;
    reset_bar = 1'b1;
  endtask

  task automatic waitGrants(input int n, input int budget, input string name);
    int c = 0;
    while (grantOrderA.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput(name, grantOrderA.size(), n);
  endtask

  initial begin
    reset_bar = 1'b1;
    applyStimulus(8'h00, 1'b0);
    #1 reset_bar = 1'b0;
    #2;
    checkOutput("reset.grant", gA, 0);
    checkOutput("reset.oe_bar", oeA, 1);
    checkOutput("reset.mux_s", sA, 0);
    checkOutput("reset.busy", bA, 0);
    checkOutput("reset.timeout", tA, 0);
    checkOutput("reset.y_q", yA, 0);

    // Single request 0x10, then drop it after the first grant cycle
    doReset();
    applyStimulus(8'h10, 1'b1);
    @(negedge clk);
    checkOutput("single.mux_s_e1", sA, 4);
    checkOutput("single.oe_bar_e1", oeA, 0);
    checkOutput("single.grant_e1", gA, 0);
    checkOutput("settle0.grant_e1", gB, 8'h10);
    checkOutput("settle0.y_q_e1", yB, 1);
    @(negedge clk);
    checkOutput("single.grant_e2", gA, 0);
    applyStimulus(8'h10, 1'b0);
    @(negedge clk);
    checkOutput("single.grant_e3", gA, 8'h10);
    checkOutput("single.y_q_e3", yA, 0);
    applyStimulus(8'h00, 1'b0);
    @(negedge clk);
    checkOutput("single.gap_grant", gA, 0);
    checkOutput("single.gap_oe_bar", oeA, 1);
    checkOutput("single.gap_busy", bA, 1);
    checkOutput("hold_edge_drop.timeout", tB, 0);
    checkOutput("hold_edge_drop.grant", gB, 0);
    @(negedge clk);
    checkOutput("single.idle_busy", bA, 0);
    checkOutput("single.model_ptr", mPtr[0], 5);

    // Round robin with every request held
    doReset();
    applyStimulus(8'hFF, 1'b1);
    waitGrants(9, 400, "rr.wait");
    for (int i = 0; i < 9 && i < grantOrderA.size(); i++)
      checkOutput($sformatf("rr.order%0d", i), grantOrderA[i], i % 8);
    checkOutput("rr.timeouts", timeoutsA, 8);
    checkOutput("rr.granting", (gA != 8'h00) ? 1 : 0, 1);

    // Asynchronous reset in the middle of a grant
    #2 reset_bar = 1'b0;
    #1;
    checkOutput("midreset.grant", gA, 0);
    checkOutput("midreset.oe_bar", oeA, 1);
    checkOutput("midreset.busy", bA, 0);
    checkOutput("midreset.mux_s", sA, 0);
    checkOutput("midreset.timeout", tA, 0);

    // Wrap: grant 6 leaves the pointer at 7, so 0x41 resolves to 0 then 6
    doReset();
    applyStimulus(8'h40, 1'b0);
    waitGrants(1, 40, "wrap.wait6");
    applyStimulus(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("wrap.model_ptr", mPtr[0], 7);
    applyStimulus(8'h41, 1'b1);
    waitGrants(3, 200, "wrap.wait");
    if (grantOrderA.size() >= 3) begin
      checkOutput("wrap.first", grantOrderA[0], 6);
      checkOutput("wrap.second", grantOrderA[1], 0);
      checkOutput("wrap.third", grantOrderA[2], 6);
    end

    // Abort: request dropped while the mux is settling
    doReset();
    applyStimulus(8'h04, 1'b1);
    @(negedge clk);
    checkOutput("abort.mux_s", sA, 2);
    applyStimulus(8'h00, 1'b1);
    @(negedge clk);
    checkOutput("abort.oe_bar", oeA, 1);
    checkOutput("abort.busy_gap", bA, 1);
    checkOutput("abort.grant", gA, 0);
    @(negedge clk);
    checkOutput("abort.busy_idle", bA, 0);
    checkOutput("abort.model_ptr", mPtr[0], 3);
    checkOutput("abort.no_grant", grantOrderA.size(), 0);
    applyStimulus(8'h0C, 1'b0);
    @(negedge clk);
    checkOutput("abort.next_winner", sA, 3);

    // Request released on the very edge the hold limit is reached
    doReset();
    applyStimulus(8'h01, 1'b1);
    begin
      int c = 0;
      while (gA == 8'h00 && c < 20) begin
        @(negedge clk);
        c++;
      end
      checkOutput("boundary.granted", gA, 8'h01);
    end
    repeat (15) @(negedge clk);
    checkOutput("boundary.still_granted", gA, 8'h01);
    applyStimulus(8'h00, 1'b0);
    @(negedge clk);
    checkOutput("boundary.timeout", tA, 0);
    checkOutput("boundary.grant", gA, 0);
    checkOutput("boundary.oe_bar", oeA, 1);

    // Randomized traffic with occasional short asynchronous resets
    doReset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      mux_y = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) req = 8'($urandom);
        else req = 8'($urandom) & 8'($urandom) & 8'($urandom);
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 reset_bar = 1'b0;
        #1 reset_bar = 1'b1;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
